tcdm_mem_responder: RTL and testbench

- Slave-side responder for the PULP TCDM/L2 request-grant bus, i.e. the far end of the core data and instruction master ports.
- Holds a single-ported word memory and answers each granted request with exactly one r_valid, one cycle after the grant.
- Supports configurable grant wait-states, optionally pseudo-random, and flags out-of-range accesses with an error response.
- Used as an L2 bank model and as a stall-injecting slave for FC subsystem verification.

---
 rtl/tcdm_mem_responder_if.sv | 27 ++
 rtl/tcdm_mem_responder.sv | 137 +++++++++++++
 tb/tb_tcdm_mem_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_mem_responder_if.sv
// Request/grant/response bundle of the PULP TCDM/L2 bus. The core side
// (master) raises requests; the memory side (slave) grants them and returns
// one response per grant.
interface tcdm_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    req_i;
  logic [ADDR_WIDTH-1:0]   add_i;
  logic                    wen_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic                    gnt_o;
  logic                    r_valid_o;
  logic [DATA_WIDTH-1:0]   r_rdata_o;
  logic                    r_opc_o;

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
  );

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, r_valid_o, r_rdata_o, r_opc_o
  );
endinterface

// File: rtl/tcdm_mem_responder.sv
// TCDM/L2 slave model: single-ported word memory behind a request/grant
// handshake with optional (pseudo-random) grant wait-states. Every grant
// produces exactly one response in the following cycle; accesses outside
// the memory window answer with r_opc_o=1 and leave the memory untouched.
module tcdm_mem_responder #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEM_WORDS    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1C00_0000,
  parameter int unsigned           WAIT_CYCLES  = 0,
  parameter bit                    RANDOM_STALL = 1'b0,
  parameter logic [15:0]           LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tcdm_mem_responder_if.slave  bus
);

  localparam int unsigned           IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);
  localparam logic [15:0]           STALL_MOD = 16'(WAIT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             count_q, count_d;
  logic [15:0]            lfsr_q;
  logic                   lfsr_fb;
  logic [7:0]             w_load;
  logic                   gnt_fsm;
  logic                   gnt;

  logic [ADDR_WIDTH-1:0]  off;
  logic                   in_range;
  logic [IDX_W-1:0]       idx;

  logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];

  logic                   r_valid_p1;
  logic                   r_opc_p1;
  logic [DATA_WIDTH-1:0]  r_rdata_p1;

  // Address decode: window check on the byte offset, word index from its low bits.
  assign off      = bus.add_i - BASE_ADDR;
  assign in_range = (bus.add_i >= BASE_ADDR) && (off < MEM_BYTES);
  assign idx      = off[IDX_W+1:2];

  // Stall length for the request now presented in IDLE.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign w_load  = RANDOM_STALL ? 8'(lfsr_q % STALL_MOD) : 8'(WAIT_CYCLES);

  // Grant FSM state and remaining-stall counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and grant. The IDLE cycle that sees the request already
  // counts as the first stall cycle, so WAIT is entered with W-1 left and the
  // grant lands in the (W+1)-th cycle of a continuously held request.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gnt_fsm = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          if (w_load == 8'd0) begin
            gnt_fsm = 1'b1;
          end else begin
            state_d = S_WAIT;
            count_d = w_load - 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (!bus.req_i) begin
          state_d = S_IDLE;
        end else if (count_q == 8'd0) begin
          gnt_fsm = 1'b1;
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant is forced low while reset is held, even though it is combinational.
  assign gnt       = gnt_fsm & rst_ni;
  assign bus.gnt_o = gnt;

  // Stall LFSR steps once per grant so consecutive requests see new waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else if (RANDOM_STALL && gnt) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Memory array: byte-enabled write at the grant edge, no reset.
  always_ff @(posedge clk_i) begin
    if (gnt && !bus.wen_i && in_range) begin
      for (int n = 0; n < DATA_WIDTH / 8; n++) begin
        if (bus.be_i[n]) begin
          mem[idx][8*n +: 8] <= bus.wdata_i[8*n +: 8];
        end
      end
    end
  end

  // ---- stage p1: response one cycle after the grant ----
  // Response register; data and error flag are zero whenever no response is due.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_p1 <= 1'b0;
      r_opc_p1   <= 1'b0;
      r_rdata_p1 <= '0;
    end else begin
      r_valid_p1 <= gnt;
      r_opc_p1   <= gnt && !in_range;
      r_rdata_p1 <= (gnt && bus.wen_i && in_range) ? mem[idx] : '0;
    end
  end

  assign bus.r_valid_o = r_valid_p1;
  assign bus.r_opc_o   = r_opc_p1;
  assign bus.r_rdata_o = r_rdata_p1;

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Bench for tcdm_mem_responder: three instances (no wait, fixed 3 waits,
// random 0..7 waits) driven from one clock and one reset.
module tb_tcdm_mem_responder;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic clk;
  logic rst_n;

  logic [2:0]  req, wen, gnt, rvalid, opc;
  logic [31:0] add   [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic [31:0] rdata [3];

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard state
  logic [31:0] mmem [3][1024];
  bit          mwr  [3][1024];
  bit          pv   [3];
  bit          pc   [3];
  logic [31:0] pr   [3];
  logic        po   [3];
  int          gcount [3];
  int          vcount [3];
  bit [15:0]   lfsr_m;

  tcdm_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  tcdm_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
  tcdm_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

  assign if0.req_i = req[0];  assign if0.add_i = add[0];  assign if0.wen_i = wen[0];
  assign if0.wdata_i = wdata[0];  assign if0.be_i = be[0];
  assign gnt[0] = if0.gnt_o;  assign rvalid[0] = if0.r_valid_o;
  assign rdata[0] = if0.r_rdata_o;  assign opc[0] = if0.r_opc_o;

  assign if1.req_i = req[1];  assign if1.add_i = add[1];  assign if1.wen_i = wen[1];
  assign if1.wdata_i = wdata[1];  assign if1.be_i = be[1];
  assign gnt[1] = if1.gnt_o;  assign rvalid[1] = if1.r_valid_o;
  assign rdata[1] = if1.r_rdata_o;  assign opc[1] = if1.r_opc_o;

  assign if2.req_i = req[2];  assign if2.add_i = add[2];  assign if2.wen_i = wen[2];
  assign if2.wdata_i = wdata[2];  assign if2.be_i = be[2];
  assign gnt[2] = if2.gnt_o;  assign rvalid[2] = if2.r_valid_o;
  assign rdata[2] = if2.r_rdata_o;  assign opc[2] = if2.r_opc_o;

  tcdm_mem_responder #(.WAIT_CYCLES(0)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  tcdm_mem_responder #(.WAIT_CYCLES(3), .RANDOM_STALL(1'b0)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
  tcdm_mem_responder #(.WAIT_CYCLES(7), .RANDOM_STALL(1'b1)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got no end, want end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [15:0] lfsr_step(input bit [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Hold a request until granted; check the number of stall cycles.
  task automatic do_txn(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int exp_w);
    int cyc = 0;
    bit got = 0;
    while (!got && cyc < 300) begin
      @(posedge clk); #1;
      req[i] = 1'b1; wen[i] = w; add[i] = a; wdata[i] = d; be[i] = b;
      @(negedge clk);
      cyc++;
      if (gnt[i]) got = 1;
    end
    if (!got) chk($sformatf("grant_timeout_%0d", i), 32'd0, 32'd1);
    else      chk($sformatf("wait_cycles_%0d", i), 32'(cyc - 1), 32'(exp_w));
  endtask

  task automatic idle(input int i);
    @(posedge clk); #1;
    req[i] = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: one response expected in the cycle after every grant.
  initial begin
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0; gcount[i] = 0; vcount[i] = 0;
      for (int k = 0; k < 1024; k++) mwr[i][k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          pv[i] = 0;
        end else begin
          chk($sformatf("r_valid_%0d", i), 32'(rvalid[i]), 32'(pv[i]));
          if (pv[i]) begin
            chk($sformatf("r_opc_%0d", i), 32'(opc[i]), 32'(po[i]));
            if (pc[i]) chk($sformatf("r_rdata_%0d", i), rdata[i], pr[i]);
          end else begin
            chk($sformatf("idle_rdata_%0d", i), rdata[i], 32'd0);
            chk($sformatf("idle_opc_%0d", i), 32'(opc[i]), 32'd0);
          end
          chk($sformatf("gnt_without_req_%0d", i), 32'(gnt[i] & ~req[i]), 32'd0);
          if (rvalid[i]) vcount[i]++;
          pv[i] = gnt[i];
          if (gnt[i]) begin
            logic [31:0] a;
            bit inr;
            int wd;
            gcount[i]++;
            a   = add[i];
            inr = (a >= BASE) && ((a - BASE) < 32'h1000);
            wd  = int'((a - BASE) >> 2) & 1023;
            po[i] = !inr;
            pr[i] = 32'd0;
            pc[i] = 1;
            if (wen[i]) begin
              if (inr) begin
                pr[i] = mmem[i][wd];
                pc[i] = mwr[i][wd];
              end
            end else if (inr) begin
              for (int n = 0; n < 4; n++)
                if (be[i][n]) mmem[i][wd][8*n +: 8] = wdata[i][8*n +: 8];
              if (be[i] != 4'b0000) mwr[i][wd] = 1;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] er;
    logic        eo;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0, 32'h1C000010, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 32'h1C000010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h1C000010, 32'h11223344, 4'h5, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b1, 32'h1C000010, 32'h00000000, 4'h0, 32'hDE22BE44, 1'b0};
    tbl[4]  = '{1'b0, 32'h1C000FFC, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
    tbl[5]  = '{1'b0, 32'h1C000000, 32'h0BADC0DE, 4'hF, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b1, 32'h1C001000, 32'h00000000, 4'hF, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b0, 32'h1BFFFFFC, 32'h12345678, 4'hF, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 32'h1C001000, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
    tbl[9]  = '{1'b1, 32'h1C000FFC, 32'h00000000, 4'hF, 32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b1, 32'h1C000000, 32'h00000000, 4'hF, 32'h0BADC0DE, 1'b0};
    tbl[11] = '{1'b0, 32'h1C000010, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0};
    tbl[12] = '{1'b1, 32'h1C000013, 32'h00000000, 4'hF, 32'hDE22BE44, 1'b0};
    tbl[13] = '{1'b1, 32'h00000000, 32'h00000000, 4'hF, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    req = '0; wen = '1;
    for (int i = 0; i < 3; i++) begin
      add[i] = BASE; wdata[i] = '0; be[i] = '0;
    end
    lfsr_m = 16'hACE1;

    // reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_gnt_%0d", i), 32'(gnt[i]), 32'd0);
      chk($sformatf("rst_rvalid_%0d", i), 32'(rvalid[i]), 32'd0);
      chk($sformatf("rst_rdata_%0d", i), rdata[i], 32'd0);
      chk($sformatf("rst_opc_%0d", i), 32'(opc[i]), 32'd0);
    end
    #2 rst_n = 1'b1;

    // table vectors on the zero-wait instance
    for (int k = 0; k < 14; k++) begin
      do_txn(0, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].b, 0);
      chk($sformatf("tbl%0d_prev_rvalid", k), 32'(rvalid[0]), 32'd0);
      idle(0);
      chk($sformatf("tbl%0d_rvalid", k), 32'(rvalid[0]), 32'd1);
      chk($sformatf("tbl%0d_rdata", k), rdata[0], tbl[k].er);
      chk($sformatf("tbl%0d_opc", k), 32'(opc[0]), 32'(tbl[k].eo));
    end

    // full throughput, read right after write to the same word
    do_txn(0, 1'b0, 32'h1C000020, 32'h55AA55AA, 4'hF, 0);
    do_txn(0, 1'b1, 32'h1C000020, 32'h0, 4'h0, 0);
    chk("b2b_wr_rvalid", 32'(rvalid[0]), 32'd1);
    do_txn(0, 1'b1, 32'h1C000FFC, 32'h0, 4'h0, 0);
    chk("b2b_raw_rdata", rdata[0], 32'h55AA55AA);
    idle(0);
    chk("b2b_last_rdata", rdata[0], 32'hCAFEF00D);

    // fixed 3 wait-states, request held across two transactions
    do_txn(1, 1'b0, 32'h1C000040, 32'h01020304, 4'hF, 3);
    do_txn(1, 1'b1, 32'h1C000040, 32'h0, 4'h0, 3);
    idle(1);
    chk("w3_rvalid", 32'(rvalid[1]), 32'd1);
    chk("w3_rdata", rdata[1], 32'h01020304);

    // abort after 2 cycles: no grant, no response, next request waits fully
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1; req[1] = 1'b1; wen[1] = 1'b1; add[1] = 32'h1C000040;
      @(negedge clk);
      chk("abort_gnt", 32'(gnt[1]), 32'd0);
    end
    for (int c = 0; c < 2; c++) begin
      idle(1);
      chk("abort_gnt_after", 32'(gnt[1]), 32'd0);
      chk("abort_rvalid", 32'(rvalid[1]), 32'd0);
    end
    do_txn(1, 1'b1, 32'h1C000040, 32'h0, 4'h0, 3);
    idle(1);

    // reset while a grant is due (inst 1) and a response is showing (inst 0)
    @(posedge clk); #1; req[1] = 1'b1; wen[1] = 1'b1; add[1] = 32'h1C000040;
    @(negedge clk); chk("rstw_gnt_c1", 32'(gnt[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("rstw_gnt_c2", 32'(gnt[1]), 32'd0);
    @(posedge clk); #1; req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h1C000010;
    @(negedge clk);
    chk("rstw_gnt_c3", 32'(gnt[1]), 32'd0);
    chk("rstw_gnt0", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1; req[0] = 1'b0;
    #1;
    chk("rstw_gnt_c4", 32'(gnt[1]), 32'd1);
    chk("rstw_rvalid0_pre", 32'(rvalid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_gnt_async", 32'(gnt[1]), 32'd0);
    chk("rstw_rvalid_async", 32'(rvalid[0]), 32'd0);
    chk("rstw_rdata_async", rdata[0], 32'd0);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    lfsr_m = 16'hACE1;
    do_txn(1, 1'b1, 32'h1C000040, 32'h0, 4'h0, 3);
    idle(1);

    // random traffic on the random-stall instance
    for (int k = 0; k < 1000; k++) begin
      logic        w;
      logic [31:0] a;
      int          r;
      int          ew;
      w = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = BASE + 32'h1000 + 4 * $urandom_range(0, 255);
      else if (r == 1) a = BASE - 4 * $urandom_range(1, 64);
      else             a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      ew = int'(lfsr_m % 16'd8);
      do_txn(2, w, a, $urandom, 4'($urandom_range(0, 15)), ew);
      lfsr_m = lfsr_step(lfsr_m);
      repeat ($urandom_range(0, 2)) idle(2);
    end
    idle(2);
    idle(2);
    chk("rand_grant_vs_rvalid", 32'(vcount[2]), 32'(gcount[2]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
